return_stack: RTL
=================

Name: return_stack

Overview:
- Hardware return-address stack serving the StR/StW requests the control unit issues in ST_STAGE.
- StW (JAL) pushes the link address (PC+1).
- StR (stop-bit return / J with stop bit) pops the saved address toward the PCsrc=0 input of the PC mux.
- Sits beside the PC datapath.
- Requests are driven on the clock's falling edge and sampled here on the rising edge.

Parameters:
- AW, 16, width of a stored address (PC width).
- DEPTH, 8, number of entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- StW  input  1  push request from control unit.
- StR  input  1  pop request from control unit.
- push_addr  input  AW  address to push (PC+1), sampled when StW=1.
- pop_addr  output  AW  registered address returned by the most recent successful pop.
- pop_valid  output  1  one-cycle pulse, high the cycle after a successful pop.
- top_addr  output  AW  combinational view of the current top entry; 0 when empty.
- count  output  CW  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.
- clr_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pointer=0, count=0, pop_addr=0, pop_valid=0, overflow=0, underflow=0.
  - Storage contents are don't-care but read as 0 via top_addr while empty.
  - Asserting reset mid-operation discards all entries immediately.
- Storage is a DEPTH-entry array indexed by sp (the next free slot). Top = entry[sp-1].
- Push only (StW=1, StR=0):
  - not full: entry[sp]<=push_addr; sp+1; count+1.
  - full: no change to storage or sp; overflow<=1.
- Pop only (StR=1, StW=0):
  - not empty: pop_addr<=entry[sp-1]; sp-1; count-1; pop_valid<=1 next cycle.
  - empty: pop_addr holds; pop_valid=0; underflow<=1.
- Simultaneous (StR=1, StW=1): replace-top.
  - not empty: pop_addr<=old top; entry[sp-1]<=push_addr; sp and count unchanged; pop_valid<=1.
  - empty: treated as a push; underflow<=1; pop_valid=0.
- Pop latency: 1 cycle. pop_addr and pop_valid are both valid after the rising edge that sampled StR.
- pop_valid is high for exactly one cycle per successful pop. Back-to-back pops each give a fresh pulse and value.
- Requests are level-sampled every rising edge. A request held high N edges performs N operations. The control unit clears StR/StW outside ST_STAGE.
- Sticky flags:
  - clr_err=1 clears overflow/underflow on that edge.
  - A new error in the same cycle as clr_err wins (flag set).
- count arithmetic is CW bits and never wraps. sp wraps only through the full/empty guards, never silently.
- top_addr is combinational from storage and sp, with no registered delay.

Decomposition:
- Shared package rs_pkg:
  - ST_STAGE='b101 and the other stage encodings used by the control unit.
  - Default AW/DEPTH.
  - enum of op kinds {NOP, PUSH, POP, REPL} derived from {StW,StR}.
- One sub-module, return_stack_mem:
  - DEPTH x AW register array, one synchronous write port, one asynchronous read port at sp-1.
  - No reset on storage.
- Pointer/count/flag logic stays in return_stack.

Test Plan:
- Reset then idle: count=0, empty=1, top_addr=0, pop_valid=0. Assert rst_n=0 mid-stack with count=3 -> count=0 immediately, without waiting for a clock.
- Push 0x0010, 0x0020, 0x0030, then pop three times -> pop_addr 0x0030, 0x0020, 0x0010, each with a one-cycle pop_valid; empty=1 after.
- Push 8 times (0x0100..0x0107) -> full=1. 9th push 0x0999 -> overflow=1, count=8, top_addr=0x0107. clr_err -> overflow=0.
- Pop on empty -> underflow=1, pop_valid=0, pop_addr unchanged. Same-cycle clr_err and empty pop -> underflow stays 1.
- Stack holding [0x0040, 0x0050]; StR=StW=1 with push_addr=0x0077 -> pop_addr=0x0050, pop_valid=1, count=2, top_addr=0x0077.
- StW driven on the falling edge by the control-unit model with push_addr=0x1234, held for one cycle -> exactly one push, count=1. Held two cycles -> count=2.

Source files
------------

// File: rtl/return_stack_pkg.sv
// Shared definitions for the return-address stack.
// Holds control-unit stage encodings, default sizes and the op-kind enum.
package rs_pkg;

   // Stage encodings used by the control unit; StW/StR only fire in ST_STAGE
   localparam logic [2:0] ST_FETCH  = 3'b000;
   localparam logic [2:0] ST_DECODE = 3'b001;
   localparam logic [2:0] ST_EXEC   = 3'b010;
   localparam logic [2:0] ST_MEM    = 3'b011;
   localparam logic [2:0] ST_WB     = 3'b100;
   localparam logic [2:0] ST_STAGE  = 3'b101;

   localparam int RS_AW    = 16;
   localparam int RS_DEPTH = 8;

   // Encoded directly as {StW,StR}
   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } rs_op_e;

   function automatic rs_op_e rs_op(input logic stw, input logic str);
      return rs_op_e'({stw, str});
   endfunction

endpackage

// File: rtl/return_stack_if.sv
// Control-unit <-> return-stack request/response bundle.
// master: StW/StR/push_addr/clr_err out; slave: pop/top/status out.
interface return_stack_if
   import rs_pkg::*;
#(
   parameter int AW    = RS_AW,
   parameter int DEPTH = RS_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
);
   logic          StW;
   logic          StR;
   logic [AW-1:0] push_addr;
   logic          clr_err;
   logic [AW-1:0] pop_addr;
   logic          pop_valid;
   logic [AW-1:0] top_addr;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          underflow;

   modport master (
      output StW, StR, push_addr, clr_err,
      input  pop_addr, pop_valid, top_addr, count,
      input  empty, full, overflow, underflow
   );

   modport slave (
      input  StW, StR, push_addr, clr_err,
      output pop_addr, pop_valid, top_addr, count,
      output empty, full, overflow, underflow
   );
endinterface

// File: rtl/return_stack_mem.sv
// DEPTH x AW storage: one synchronous write port, one async read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module return_stack_mem #(
   parameter int AW    = 16,
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [PW-1:0] waddr_i,
   input  logic [AW-1:0] wdata_i,
   input  logic [PW-1:0] raddr_i,
   output logic [AW-1:0] rdata_o
);

   logic [AW-1:0] mem_q [DEPTH];

   // Contents are meaningless while empty, so no reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack: StW pushes PC+1, StR pops to the PC mux.
// Ports: clk, rst_n (async low), bus (return_stack_if.slave).
module return_stack
   import rs_pkg::*;
#(
   parameter int AW    = RS_AW,
   parameter int DEPTH = RS_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input logic          clk,
   input logic          rst_n,
   return_stack_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] SP_ONE   = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [PW-1:0] sp_q, sp_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] pop_addr_q, pop_addr_d;
   logic          pop_valid_q, pop_valid_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic          we;
   logic [PW-1:0] waddr;
   logic [PW-1:0] top_idx;
   logic [AW-1:0] top_raw;
   logic          is_empty;
   logic          is_full;
   logic          ovf_set;
   logic          unf_set;
   rs_op_e        op;

   assign op       = rs_op(bus.StW, bus.StR);
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);
   assign top_idx  = sp_q - SP_ONE;

   return_stack_mem #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (bus.push_addr),
      .raddr_i (top_idx),
      .rdata_o (top_raw)
   );

   always_comb begin
      sp_d        = sp_q;
      count_d     = count_q;
      pop_addr_d  = pop_addr_q;
      pop_valid_d = 1'b0;
      we          = 1'b0;
      waddr       = sp_q;
      ovf_set     = 1'b0;
      unf_set     = 1'b0;
      unique case (op)
         OP_NOP: ;
         OP_PUSH: begin
            if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               we      = 1'b1;
               sp_d    = sp_q + SP_ONE;
               count_d = count_q + CNT_ONE;
            end
         end
         OP_POP: begin
            if (is_empty) begin
               unf_set = 1'b1;
            end else begin
               pop_addr_d  = top_raw;
               pop_valid_d = 1'b1;
               sp_d        = top_idx;
               count_d     = count_q - CNT_ONE;
            end
         end
         OP_REPL: begin
            if (is_empty) begin
               // Nothing to return: behave as a plain push (cannot be full)
               unf_set = 1'b1;
               we      = 1'b1;
               sp_d    = sp_q + SP_ONE;
               count_d = count_q + CNT_ONE;
            end else begin
               pop_addr_d  = top_raw;
               pop_valid_d = 1'b1;
               we          = 1'b1;
               waddr       = top_idx;
            end
         end
         default: ;
      endcase
      // A fresh error beats a same-cycle clear
      ovf_d = (ovf_q & ~bus.clr_err) | ovf_set;
      unf_d = (unf_q & ~bus.clr_err) | unf_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q        <= '0;
         count_q     <= '0;
         pop_addr_q  <= '0;
         pop_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         count_q     <= count_d;
         pop_addr_q  <= pop_addr_d;
         pop_valid_q <= pop_valid_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign bus.pop_addr  = pop_addr_q;
   assign bus.pop_valid = pop_valid_q;
   assign bus.top_addr  = is_empty ? '0 : top_raw;
   assign bus.count     = count_q;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;

endmodule
